// File: rtl/packet_writer_pkg.sv
// Shared definitions for the receive-side packet writer: widths, FSM encoding
// and the helper that left-justifies a partial final octet.
package packet_writer_pkg;

   localparam int unsigned BLE_MEM_DATA   = 8;
   localparam int unsigned BLE_MEM_ADDR   = 8;
   localparam int unsigned BLE_OCTET_BITS = 8;

   typedef enum logic [1:0] {
      PW_IDLE  = 2'd0,
      PW_RX    = 2'd1,
      PW_FLUSH = 2'd2,
      PW_DONE  = 2'd3
   } pw_state_e;

   // Move the k most recent bits (held in sh[k-1:0]) to the top of the octet
   // and zero-fill below them. Older bits above position k-1 fall off the top.
   function automatic logic [7:0] left_justify(input logic [7:0] sh, input logic [2:0] k);
      logic [3:0] amt;
      amt = 4'd8 - {1'b0, k};
      return sh << amt;
   endfunction

endpackage

// File: rtl/packet_writer_sym_deserializer.sv
// Bit-serial to octet assembler: MSB-first shift register plus a modulo-8
// bit counter. Exposes the byte that the current strobe would complete and
// the bit count after the current strobe, so the parent can act in the same
// cycle.
module packet_writer_sym_deserializer (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       clr_i,
   input  logic       en_i,
   input  logic       bitVld_i,
   input  logic       bitVal_i,
   output logic       byteRdy_o,
   output logic [7:0] byteNext_o,
   output logic [7:0] shift_o,
   output logic [2:0] fragCnt_o,
   output logic [2:0] cntNext_o
);

   logic [7:0] shift_q, shift_d;
   logic [2:0] cnt_q, cnt_d;
   logic       take;

   assign take       = en_i && bitVld_i;
   assign byteNext_o = {shift_q[6:0], bitVal_i};
   assign cntNext_o  = take ? (cnt_q + 3'd1) : cnt_q;
   assign byteRdy_o  = take && (cnt_q == 3'd7);
   assign shift_o    = shift_q;
   assign fragCnt_o  = cnt_q;

   // Next-state: clear on packet start, otherwise shift in accepted bits.
   always_comb begin
      shift_d = shift_q;
      cnt_d   = cnt_q;
      if (clr_i) begin
         shift_d = '0;
         cnt_d   = '0;
      end else if (take) begin
         shift_d = byteNext_o;
         cnt_d   = cntNext_o;
      end
   end

   // Shift register and bit counter state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shift_q <= '0;
         cnt_q   <= '0;
      end else begin
         shift_q <= shift_d;
         cnt_q   <= cnt_d;
      end
   end

endmodule

// File: rtl/packet_writer.sv
// Receive packet writer: assembles demodulated bits into octets, writes them
// to packet memory from address 0 with a capacity check, flushes a partial
// final octet left-justified, and latches length/fragment/done for the
// controller until the next reset.
module packet_writer
   import packet_writer_pkg::*;
#(
   parameter int unsigned MEM_DATA = BLE_MEM_DATA,
   parameter int unsigned MEM_ADDR = BLE_MEM_ADDR
) (
   input  logic                clk,
   input  logic                ready,
   input  logic                symValid,
   input  logic                symVal,
   input  logic                symStart,
   input  logic                symEnd,
   input  logic [MEM_ADDR-1:0] mem_size,
   output logic [MEM_ADDR-1:0] mem_addr,
   output logic [MEM_DATA-1:0] mem_wdata,
   output logic                mem_we,
   output logic [MEM_ADDR-1:0] pktLen,
   output logic [2:0]          fragBits,
   output logic                overflow,
   output logic                packetDone
);

   pw_state_e           state_q;
   logic [MEM_ADDR-1:0] mem_addr_q;
   logic [MEM_DATA-1:0] mem_wdata_q;
   logic                mem_we_q;
   logic [MEM_ADDR-1:0] pktLen_q;
   logic [2:0]          fragBits_q;
   logic                overflow_q;
   logic                packetDone_q;

   logic                desClr;
   logic                desEn;
   logic                byteRdy;
   logic [7:0]          byteNext;
   logic [7:0]          shiftNow;
   logic [2:0]          fragCnt;
   logic [2:0]          cntNext;
   logic                memFull;

   assign desClr  = (state_q == PW_IDLE) && symStart;
   assign desEn   = (state_q == PW_RX);
   assign memFull = (pktLen_q == mem_size);

   packet_writer_sym_deserializer u_des (
      .clk        (clk),
      .rst_n      (ready),
      .clr_i      (desClr),
      .en_i       (desEn),
      .bitVld_i   (symValid),
      .bitVal_i   (symVal),
      .byteRdy_o  (byteRdy),
      .byteNext_o (byteNext),
      .shift_o    (shiftNow),
      .fragCnt_o  (fragCnt),
      .cntNext_o  (cntNext)
   );

   // Packet FSM with registered memory port and status outputs.
   always_ff @(posedge clk or negedge ready) begin
      if (!ready) begin
         state_q      <= PW_IDLE;
         mem_addr_q   <= '0;
         mem_wdata_q  <= '0;
         mem_we_q     <= 1'b0;
         pktLen_q     <= '0;
         fragBits_q   <= '0;
         overflow_q   <= 1'b0;
         packetDone_q <= 1'b0;
      end else begin
         mem_we_q <= 1'b0;
         case (state_q)
            PW_IDLE: begin
               if (symStart) begin
                  state_q <= PW_RX;
               end
            end
            PW_RX: begin
               // A completed octet is written (or dropped) before end-of-packet
               // is considered; the end decision uses the post-strobe count.
               if (byteRdy) begin
                  if (!memFull) begin
                     mem_we_q    <= 1'b1;
                     mem_addr_q  <= pktLen_q;
                     mem_wdata_q <= byteNext;
                     pktLen_q    <= pktLen_q + 1'b1;
                  end else begin
                     overflow_q  <= 1'b1;
                  end
               end
               if (symEnd) begin
                  if (cntNext == 3'd0) begin
                     state_q      <= PW_DONE;
                     fragBits_q   <= 3'd0;
                     packetDone_q <= 1'b1;
                  end else begin
                     state_q      <= PW_FLUSH;
                  end
               end
            end
            PW_FLUSH: begin
               if (!memFull) begin
                  mem_we_q    <= 1'b1;
                  mem_addr_q  <= pktLen_q;
                  mem_wdata_q <= left_justify(shiftNow, fragCnt);
                  pktLen_q    <= pktLen_q + 1'b1;
               end else begin
                  overflow_q  <= 1'b1;
               end
               fragBits_q   <= fragCnt;
               packetDone_q <= 1'b1;
               state_q      <= PW_DONE;
            end
            default: begin
               // PW_DONE: everything frozen until reset.
            end
         endcase
      end
   end

   assign mem_addr   = mem_addr_q;
   assign mem_wdata  = mem_wdata_q;
   assign mem_we     = mem_we_q;
   assign pktLen     = pktLen_q;
   assign fragBits   = fragBits_q;
   assign overflow   = overflow_q;
   assign packetDone = packetDone_q;

endmodule

// File: tb/tb_packet_writer.sv
// Scoreboard bench for packet_writer: directed packets push hand-computed
// expected writes (address, data, cycle); a monitor pops and compares every
// mem_we pulse.
module tb_packet_writer;

   logic       clk = 1'b0;
   logic       ready = 1'b0;
   logic       symValid = 1'b0;
   logic       symVal = 1'b0;
   logic       symStart = 1'b0;
   logic       symEnd = 1'b0;
   logic [7:0] mem_size = 8'd16;
   logic [7:0] mem_addr;
   logic [7:0] mem_wdata;
   logic       mem_we;
   logic [7:0] pktLen;
   logic [2:0] fragBits;
   logic       overflow;
   logic       packetDone;

   typedef struct {
      logic [7:0] a;
      logic [7:0] d;
      int         c;
   } exp_t;

   exp_t sb[$];
   int   vectors = 0;
   int   miscompares = 0;
   int   cyc = 0;
   int   last_cyc = 0;

   packet_writer dut (
      .clk        (clk),
      .ready      (ready),
      .symValid   (symValid),
      .symVal     (symVal),
      .symStart   (symStart),
      .symEnd     (symEnd),
      .mem_size   (mem_size),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_we     (mem_we),
      .pktLen     (pktLen),
      .fragBits   (fragBits),
      .overflow   (overflow),
      .packetDone (packetDone)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: every write pulse must match the oldest expected write.
   always @(negedge clk) begin
      if (mem_we) begin
         vectors++;
         if (sb.size() == 0) begin
            miscompares++;
            $display("FAIL unexpected_write: got addr=%0h data=%0h at cyc %0d, required no write",
                     mem_addr, mem_wdata, cyc);
         end else begin
            exp_t e;
            e = sb.pop_front();
            if (mem_addr !== e.a || mem_wdata !== e.d || cyc != e.c) begin
               miscompares++;
               $display("FAIL write: got addr=%0h data=%0h cyc=%0d, required addr=%0h data=%0h cyc=%0d",
                        mem_addr, mem_wdata, cyc, e.a, e.d, e.c);
            end
         end
      end
   end

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
      vectors++;
      if (act !== req) begin
         miscompares++;
         $display("FAIL %s: got %0h, required %0h", name, act, req);
      end
   endtask

   task automatic exp_wr(input logic [7:0] a, input logic [7:0] d, input int c);
      exp_t e;
      e.a = a; e.d = d; e.c = c;
      sb.push_back(e);
   endtask

   // Drive one cycle of strobes, starting just after a rising edge.
   task automatic step(input logic v, input logic b, input logic s, input logic e);
      symValid = v; symVal = b; symStart = s; symEnd = e;
      last_cyc = cyc;
      @(posedge clk); #1;
      symValid = 0; symVal = 0; symStart = 0; symEnd = 0;
   endtask

   task automatic send_bits(input logic [7:0] d, input int n, input logic end_last);
      for (int i = 7; i > 7 - n; i--)
         step(1'b1, d[i], 1'b0, (i == 8 - n) ? end_last : 1'b0);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #1;
      end
   endtask

   task automatic do_reset();
      ready = 1'b0;
      idle(2);
      ready = 1'b1;
      idle(1);
   endtask

   initial begin
      idle(2);
      // Reset state
      chk("rst_pktLen", pktLen, 8'd0);
      chk("rst_frag", {5'd0, fragBits}, 8'd0);
      chk("rst_ovf", {7'd0, overflow}, 8'd0);
      chk("rst_done", {7'd0, packetDone}, 8'd0);
      chk("rst_we", {7'd0, mem_we}, 8'd0);
      chk("rst_addr", mem_addr, 8'd0);
      chk("rst_wdata", mem_wdata, 8'd0);
      ready = 1'b1;
      idle(1);

      // IDLE ignores symValid / symEnd
      send_bits(8'hFF, 8, 1'b0);
      step(1'b0, 1'b0, 1'b0, 1'b1);
      idle(3);
      chk("idle_done", {7'd0, packetDone}, 8'd0);
      chk("idle_pktLen", pktLen, 8'd0);

      // Basic packet with symStart mid-byte (ignored)
      step(1'b0, 1'b0, 1'b1, 1'b0);
      send_bits(8'hA5, 8, 1'b0);
      exp_wr(8'd0, 8'hA5, last_cyc + 1);
      send_bits(8'h3C, 4, 1'b0);
      step(1'b0, 1'b0, 1'b1, 1'b0);
      for (int i = 3; i >= 0; i--) begin
         logic [7:0] v;
         v = 8'h3C;
         step(1'b1, v[i], 1'b0, 1'b0);
      end
      exp_wr(8'd1, 8'h3C, last_cyc + 1);
      step(1'b0, 1'b0, 1'b0, 1'b1);
      idle(3);
      chk("basic_pktLen", pktLen, 8'd2);
      chk("basic_frag", {5'd0, fragBits}, 8'd0);
      chk("basic_done", {7'd0, packetDone}, 8'd1);
      chk("basic_ovf", {7'd0, overflow}, 8'd0);

      // Sticky DONE
      step(1'b0, 1'b0, 1'b1, 1'b0);
      send_bits(8'h77, 8, 1'b0);
      step(1'b0, 1'b0, 1'b0, 1'b1);
      idle(3);
      chk("sticky_pktLen", pktLen, 8'd2);
      chk("sticky_done", {7'd0, packetDone}, 8'd1);

      // Partial final byte
      do_reset();
      step(1'b0, 1'b0, 1'b1, 1'b0);
      send_bits(8'hFF, 8, 1'b0);
      exp_wr(8'd0, 8'hFF, last_cyc + 1);
      send_bits(8'hA0, 3, 1'b0);
      step(1'b0, 1'b0, 1'b0, 1'b1);
      exp_wr(8'd1, 8'hA0, last_cyc + 2);
      idle(4);
      chk("part_pktLen", pktLen, 8'd2);
      chk("part_frag", {5'd0, fragBits}, 8'd3);
      chk("part_done", {7'd0, packetDone}, 8'd1);

      // Overflow with mem_size = 2
      do_reset();
      mem_size = 8'd2;
      step(1'b0, 1'b0, 1'b1, 1'b0);
      send_bits(8'h11, 8, 1'b0);
      exp_wr(8'd0, 8'h11, last_cyc + 1);
      send_bits(8'h22, 8, 1'b0);
      exp_wr(8'd1, 8'h22, last_cyc + 1);
      send_bits(8'h33, 8, 1'b0);
      step(1'b0, 1'b0, 1'b0, 1'b1);
      idle(3);
      chk("ovf_pktLen", pktLen, 8'd2);
      chk("ovf_flag", {7'd0, overflow}, 8'd1);
      chk("ovf_done", {7'd0, packetDone}, 8'd1);

      // mem_size = 0 with a partial byte: all dropped, fragBits still reported
      do_reset();
      mem_size = 8'd0;
      step(1'b0, 1'b0, 1'b1, 1'b0);
      send_bits(8'h9C, 8, 1'b0);
      send_bits(8'hE0, 3, 1'b0);
      step(1'b0, 1'b0, 1'b0, 1'b1);
      idle(3);
      chk("zero_pktLen", pktLen, 8'd0);
      chk("zero_ovf", {7'd0, overflow}, 8'd1);
      chk("zero_frag", {5'd0, fragBits}, 8'd3);

      // 8th bit coincident with symEnd
      do_reset();
      mem_size = 8'd16;
      step(1'b0, 1'b0, 1'b1, 1'b0);
      send_bits(8'h5A, 8, 1'b1);
      exp_wr(8'd0, 8'h5A, last_cyc + 1);
      idle(3);
      chk("sim_pktLen", pktLen, 8'd1);
      chk("sim_frag", {5'd0, fragBits}, 8'd0);
      chk("sim_done", {7'd0, packetDone}, 8'd1);

      // Reset mid-packet, then a fresh packet
      do_reset();
      step(1'b0, 1'b0, 1'b1, 1'b0);
      send_bits(8'hF8, 5, 1'b0);
      ready = 1'b0;
      #1;
      chk("abort_pktLen", pktLen, 8'd0);
      chk("abort_we", {7'd0, mem_we}, 8'd0);
      idle(2);
      ready = 1'b1;
      idle(1);
      step(1'b0, 1'b0, 1'b1, 1'b0);
      send_bits(8'hC3, 8, 1'b0);
      exp_wr(8'd0, 8'hC3, last_cyc + 1);
      step(1'b0, 1'b0, 1'b0, 1'b1);
      idle(3);
      chk("rearm_pktLen", pktLen, 8'd1);
      chk("rearm_done", {7'd0, packetDone}, 8'd1);

      // Every expected write must have been seen
      vectors++;
      if (sb.size() != 0) begin
         miscompares++;
         $display("FAIL missing_writes: got %0d outstanding, required 0", sb.size());
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
